// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bus bundle joining requesters C/D, the arbiter and DataMemory
interface dmem_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic c_req, c_we, c_gnt, c_rvalid;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata, c_rdata;
  logic d_req, d_we, d_gnt, d_rvalid;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic m_memRead, m_memWrite;
  logic [ADDR_W-1:0] m_address;
  logic [DATA_W-1:0] m_writeData, m_readData;
  modport slave (
    input  c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, m_readData,
    output c_gnt, c_rvalid, c_rdata, d_gnt, d_rvalid, d_rdata,
           m_memRead, m_memWrite, m_address, m_writeData
  );
  modport master (
    output c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, m_readData,
    input  c_gnt, c_rvalid, c_rdata, d_gnt, d_rvalid, d_rdata,
           m_memRead, m_memWrite, m_address, m_writeData
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises core (C) and debug (D) accesses onto one DataMemory port.
// Round-robin by default; define DMEM_ARB_FIXED_PRIO_EN for fixed C-over-D priority.
module dmem_arbiter #(parameter int ADDR_W = 32, parameter int DATA_W = 32) (
  input logic clk,
  input logic rst,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;
  state_t state_q, state_d;
  logic own_q, own_d, we_q, we_d, pick;
  logic [ADDR_W-1:0] addr_q, addr_d, m_addr_q, m_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d;
  logic c_gnt_q, c_gnt_d, d_gnt_q, d_gnt_d, c_rvalid_q, c_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic m_rd_q, m_rd_d, m_wr_q, m_wr_d;
`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign pick = !bus.c_req;
`else
  logic last_q, last_d;
  assign pick = bus.d_req && (!bus.c_req || !last_q);
  assign last_d = (state_q == IDLE && (bus.c_req || bus.d_req)) ? pick : last_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) last_q <= 1'b1;
    else last_q <= last_d;
`endif
  always_comb begin
    state_d = state_q;
    own_d = own_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    c_gnt_d = 1'b0;
    d_gnt_d = 1'b0;
    c_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
    m_rd_d = 1'b0;
    m_wr_d = 1'b0;
    m_addr_d = '0;
    m_wdata_d = '0;
    if (state_q == IDLE) begin
      // outputs lag state by a cycle: m_rd_q here means RDWAIT's data is on m_readData now
      if (m_rd_q) begin
        c_rvalid_d = !own_q;
        d_rvalid_d = own_q;
        c_rdata_d = own_q ? c_rdata_q : bus.m_readData;
        d_rdata_d = own_q ? bus.m_readData : d_rdata_q;
      end
      if (bus.c_req || bus.d_req) begin
        state_d = ISSUE;
        own_d = pick;
        we_d = pick ? bus.d_we : bus.c_we;
        addr_d = pick ? bus.d_addr : bus.c_addr;
        wdata_d = pick ? bus.d_wdata : bus.c_wdata;
        c_gnt_d = !pick;
        d_gnt_d = pick;
      end
    end else if (state_q == ISSUE) begin
      m_rd_d = !we_q;
      m_wr_d = we_q;
      m_addr_d = addr_q;
      m_wdata_d = wdata_q;
      state_d = we_q ? IDLE : RDWAIT;
    end else begin
      m_rd_d = 1'b1;
      m_addr_d = addr_q;
      m_wdata_d = wdata_q;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      own_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      c_gnt_q <= 1'b0;
      d_gnt_q <= 1'b0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
      m_rd_q <= 1'b0;
      m_wr_q <= 1'b0;
      m_addr_q <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      own_q <= own_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      c_gnt_q <= c_gnt_d;
      d_gnt_q <= d_gnt_d;
      c_rvalid_q <= c_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
      m_rd_q <= m_rd_d;
      m_wr_q <= m_wr_d;
      m_addr_q <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  assign bus.c_gnt = c_gnt_q;
  assign bus.d_gnt = d_gnt_q;
  assign bus.c_rvalid = c_rvalid_q;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.c_rdata = c_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.m_memRead = m_rd_q;
  assign bus.m_memWrite = m_wr_q;
  assign bus.m_address = m_addr_q;
  assign bus.m_writeData = m_wdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter against a synchronous RAM + MMIO model
module tb_dmem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] input_port = '0;
  logic [31:0] mem [0:255];
  int n_cmp = 0, n_bad = 0, viol = 0;
  int n;
  bit other;
  int order [$];
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.m_memWrite && bus.m_address < 32'hFFFF0000) mem[bus.m_address[9:2]] <= bus.m_writeData;
    bus.m_readData <= (bus.m_address >= 32'hFFFF0000) ? input_port : mem[bus.m_address[9:2]];
  end
  always @(negedge clk)
    if (rst === 1'b0 && ((bus.c_gnt && bus.d_gnt) || (bus.c_rvalid && bus.d_rvalid))) viol++;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic req(input bit d, input bit on, input bit we, input logic [31:0] a, input logic [31:0] w);
    if (d) begin bus.d_req = on; bus.d_we = we; bus.d_addr = a; bus.d_wdata = w; end
    else begin bus.c_req = on; bus.c_we = we; bus.c_addr = a; bus.c_wdata = w; end
  endtask
  task automatic wait_gnt(input bit d, output int k);
    k = 0;
    do begin tick; k++; end while (!(d ? bus.d_gnt : bus.c_gnt) && k < 8);
  endtask
  task automatic wait_rv(input bit d, output int k, output bit oth);
    k = 0;
    oth = 0;
    do begin
      tick;
      k++;
      oth |= d ? bus.c_rvalid : bus.d_rvalid;
    end while (!(d ? bus.d_rvalid : bus.c_rvalid) && k < 8);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    req(0, 0, 0, 0, 0);
    req(1, 0, 0, 0, 0);
    tick;
    tick;
    rst = 1'b0;
    tick;
    chk("reset_ctl", {bus.c_gnt, bus.d_gnt, bus.c_rvalid, bus.d_rvalid, bus.m_memRead, bus.m_memWrite}, 0);
    chk("reset_bus", {bus.m_address, bus.m_writeData}, 0);
    chk("reset_rdata", {bus.c_rdata, bus.d_rdata}, 0);
    req(0, 1, 1, 32'h10, 32'hDEADBEEF);
    wait_gnt(0, n);
    chk("c_wr_gnt_lat", n, 1);
    req(0, 0, 0, 0, 0);
    tick;
    chk("c_wr_strobe", {bus.m_memWrite, bus.m_memRead}, 2'b10);
    chk("c_wr_addr", bus.m_address, 32'h10);
    chk("c_wr_data", bus.m_writeData, 32'hDEADBEEF);
    tick;
    chk("c_wr_one_cycle", bus.m_memWrite, 0);
    req(0, 1, 0, 32'h10, 0);
    wait_gnt(0, n);
    chk("c_rd_gnt_lat", n, 1);
    req(0, 0, 0, 0, 0);
    tick;
    chk("c_rd_issue", {bus.m_memRead, bus.m_memWrite, bus.m_address}, {2'b10, 32'h10});
    tick;
    chk("c_rd_wait", {bus.m_memRead, bus.m_address, bus.c_rvalid}, {1'b1, 32'h10, 1'b0});
    tick;
    chk("c_rd_rvalid", {bus.c_rvalid, bus.d_rvalid}, 2'b10);
    chk("c_rd_rdata", bus.c_rdata, 32'hDEADBEEF);
    tick;
    chk("c_rd_pulse", {bus.c_rvalid, bus.m_memRead}, 0);
    chk("c_rd_hold", bus.c_rdata, 32'hDEADBEEF);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    req(0, 1, 0, 32'h10, 0);
    req(1, 1, 0, 32'h10, 0);
    for (int i = 0; i < 16; i++) begin
      tick;
      if (bus.c_gnt) order.push_back(0);
      if (bus.d_gnt) order.push_back(1);
    end
    req(0, 0, 0, 0, 0);
    req(1, 0, 0, 0, 0);
    repeat (5) tick;
    chk("arb_grant_count", order.size(), 6);
    for (int i = 0; i < 4; i++)
`ifdef DMEM_ARB_FIXED_PRIO_EN
      chk($sformatf("arb_order%0d", i), order[i], 0);
`else
      chk($sformatf("arb_order%0d", i), order[i], i % 2);
`endif
    input_port = 32'h0000A5A5;
    req(1, 1, 0, 32'hFFFF0000, 0);
    wait_gnt(1, n);
    chk("mmio_gnt_lat", n, 1);
    req(1, 0, 0, 0, 0);
    wait_rv(1, n, other);
    chk("mmio_rv_lat", n, 3);
    chk("mmio_rdata", bus.d_rdata, 32'h0000A5A5);
    chk("mmio_no_c_rvalid", other, 0);
    tick;
    req(1, 1, 0, 32'h10, 0);
    wait_gnt(1, n);
    chk("b2b_d_gnt_lat", n, 1);
    req(1, 0, 0, 0, 0);
    req(0, 1, 1, 32'h20, 32'h12345678);
    wait_rv(1, n, other);
    chk("b2b_d_rv_lat", n, 3);
    chk("b2b_same_cycle", {bus.d_rvalid, bus.c_gnt}, 2'b11);
    chk("b2b_d_rdata", bus.d_rdata, 32'hDEADBEEF);
    req(0, 0, 0, 0, 0);
    tick;
    chk("b2b_wr", {bus.m_memWrite, bus.m_address, bus.m_writeData}, {1'b1, 32'h20, 32'h12345678});
    tick;
    req(0, 1, 0, 32'h20, 0);
    wait_gnt(0, n);
    chk("rst_rd_gnt_lat", n, 1);
    req(0, 0, 0, 0, 0);
    tick;
    chk("rst_rd_active", bus.m_memRead, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_ctl", {bus.c_gnt, bus.d_gnt, bus.c_rvalid, bus.d_rvalid, bus.m_memRead, bus.m_memWrite}, 0);
    chk("rst_async_bus", {bus.m_address, bus.m_writeData}, 0);
    chk("rst_async_rdata", {bus.c_rdata, bus.d_rdata}, 0);
    tick;
    rst = 1'b0;
    n = 0;
    repeat (5) begin tick; n += int'(bus.c_rvalid) + int'(bus.d_rvalid); end
    chk("rst_no_rvalid", n, 0);
    req(0, 1, 0, 32'h20, 0);
    wait_gnt(0, n);
    chk("post_rst_gnt_lat", n, 1);
    req(0, 0, 0, 0, 0);
    wait_rv(0, n, other);
    chk("post_rst_rv_lat", n, 3);
    chk("post_rst_rdata", bus.c_rdata, 32'h12345678);
    chk("exclusive_pulses", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
